hex_keypad_entry: RTL and testbench
===================================

// Module: hex_keypad_entry
// PURPOSE
//   Input-side companion of the 7-segment display driver: scans a 4x4 hex matrix keypad.
//   Debounces presses and assembles keyed hex digits into a 32-bit value, data[32:1].
//   data[32:1] feeds the display driver's data[32:1] directly, so keyed digits appear on the tubes.
//   Sits between the board keypad pins and the display/regfile data path.
// PARAMETERS
//   SCAN_DIV         20000  clk cycles each column is driven before its rows are sampled (>=4)
//   DEBOUNCE_FRAMES  4      consecutive identical full scan frames to accept a press / release (>=2)
// PORTS
//   clk        in   1   system clock, all state on posedge
//   rst        in   1   asynchronous, active-high reset
//   row_n      in   4   keypad rows, active-low (pulled up off-chip), asynchronous to clk
//   clr        in   1   synchronous clear of data, one-cycle pulse
//   col_n      out  4   keypad column drive, active-low, exactly one bit low at all times
//   data       out  32  assembled value [32:1]; newest digit in data[4:1]
//   key_code   out  4   code of last accepted key = {row_idx[1:0], col_idx[1:0]}
//   key_valid  out  1   one-cycle pulse when a key is accepted
//   key_held   out  1   high from acceptance until release is debounced
// BEHAVIOUR
//   Reset values: col_n=4'b1110, data=0, key_code=0, key_valid=0, key_held=0.
//   Reset values: state=IDLE, all counters=0, synchronizer=4'hF.
//   Sync: row_n passes a 2-flop synchronizer; samples use the synchronized value.
//   Scan: div counts 0..SCAN_DIV-1; col_idx 0..3, col_n = ~(1<<col_idx).
//   Scan: at div==SCAN_DIV-1, sample rows for col_idx, then advance col_idx (3 wraps to 0).
//   Frame: one pass of columns 0..3 (4*SCAN_DIV cycles); evaluated the cycle after col 3 is sampled.
//   Frame result: NONE (no row low), SINGLE(code) (exactly one key in frame), MULTI (>=2 keys).
//   FSM IDLE: SINGLE(k) -> cand=k, fcnt=1, DEBOUNCE; NONE/MULTI -> stay in IDLE.
//   FSM DEBOUNCE: SINGLE(cand) -> fcnt++; on the DEBOUNCE_FRAMES-th match, accept and go HELD.
//   FSM DEBOUNCE: any other result -> IDLE, fcnt=0.
//   Accept (single cycle): key_valid=1, key_code=cand, data={data[28:1],cand}, key_held=1.
//   Accept: data[32:29] is discarded, no wrap-around.
//   FSM HELD: NONE -> rcnt++; on the DEBOUNCE_FRAMES-th consecutive NONE, key_held=0 and go IDLE.
//   FSM HELD: SINGLE/MULTI -> rcnt=0; no re-trigger while held; a second key is ignored.
//   Latency: key_valid rises 1 cycle after the col-3 sample of the accepting frame.
//   clr: data<=0 next cycle, in any state; scan and FSM are unaffected.
//   clr coincident with accept: data={28'h0,cand}.
//   rst mid-operation: everything returns to reset values at once; a pending candidate is lost.
//   rst mid-operation: no key_valid is emitted.
//   key_valid is never high on two consecutive cycles.
// TESTING (bench: SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame=16 cycles, keypad model drives row_n from col_n)
//   Press key 5 (row1,col1), hold 10 frames -> exactly one key_valid, key_code=5, data=32'h0000_0005.
//   Release key 5 (3 empty frames), then press key A -> data=32'h0000_005A, key_held high per press.
//   Bounce: key 3 held 1 frame then released -> no key_valid, data unchanged, state returns IDLE.
//   Keys 1 and 2 held together for 10 frames -> no key_valid; MULTI frames never accept.
//   Nine presses 1..9 -> data=32'h2345_6789 (digit 1 shifted out); clr pulse -> data=0 next cycle.
//   rst asserted in DEBOUNCE after 2 matching frames -> col_n=1110, data=0, no key_valid pulse.

Source files
------------

// File: rtl/hex_keypad_entry.sv
// hex_keypad_entry: 4x4 hex keypad scanner with debounce
// and a 32-bit shift-in digit register for the display.
module hex_keypad_entry #(
  parameter int SCAN_DIV        = 20000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_n,
  input  logic        clr,
  output logic [3:0]  col_n,
  output logic [32:1] data,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD
  } state_t;

  logic [3:0]    sync1, sync2;
  logic [DW-1:0] div;
  logic [1:0]    col_idx;
  logic [1:0]    frm_cnt;
  logic [3:0]    frm_code;
  logic          frm_done;
  logic          samp;
  logic [3:0]    rl;
  logic [1:0]    row_idx;

  state_t        state, state_n;
  logic [3:0]    cand, cand_n;
  logic [CW-1:0] fcnt, fcnt_n;
  logic [CW-1:0] rcnt, rcnt_n;
  logic [32:1]   data_n;
  logic [3:0]    key_code_n;
  logic          key_valid_n;
  logic          key_held_n;
  logic          accept;
  logic          f_none, f_single;

  assign col_n    = ~(4'b0001 << col_idx);
  assign samp     = (div == DW'(SCAN_DIV - 1));
  assign rl       = ~sync2;
  assign f_none   = (frm_cnt == 2'd0);
  assign f_single = (frm_cnt == 2'd1);

  // Row index of a single pressed row in the sampled column.
  always_comb begin
    row_idx = 2'd0;
    if ($onehot(rl)) begin
      unique case (1'b1)
        rl[0]: row_idx = 2'd0;
        rl[1]: row_idx = 2'd1;
        rl[2]: row_idx = 2'd2;
        rl[3]: row_idx = 2'd3;
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= row_n;
      sync2 <= sync1;
    end
  end

  // Column scan timing and per-frame key accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div      <= '0;
      col_idx  <= 2'd0;
      frm_cnt  <= 2'd0;
      frm_code <= 4'd0;
      frm_done <= 1'b0;
    end else begin
      frm_done <= samp && (col_idx == 2'd3);
      if (samp) begin
        div     <= '0;
        col_idx <= col_idx + 2'd1;
      end else begin
        div <= div + DW'(1);
      end
      if (frm_done) begin
        frm_cnt  <= 2'd0;
        frm_code <= 4'd0;
      end else if (samp && (rl != 4'd0)) begin
        if ($onehot(rl) && (frm_cnt == 2'd0)) begin
          frm_cnt  <= 2'd1;
          frm_code <= {row_idx, col_idx};
        end else begin
          frm_cnt <= 2'd2;
        end
      end
    end
  end

  // Debounce FSM and digit register next-state.
  always_comb begin
    state_n     = state;
    cand_n      = cand;
    fcnt_n      = fcnt;
    rcnt_n      = rcnt;
    key_code_n  = key_code;
    key_held_n  = key_held;
    key_valid_n = 1'b0;
    accept      = 1'b0;
    if (frm_done) begin
      unique case (state)
        IDLE: begin
          if (f_single) begin
            cand_n  = frm_code;
            fcnt_n  = CW'(1);
            state_n = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (f_single && (frm_code == cand)) begin
            if (fcnt == CW'(DEBOUNCE_FRAMES - 1)) begin
              accept      = 1'b1;
              state_n     = HELD;
              fcnt_n      = '0;
              rcnt_n      = '0;
              key_valid_n = 1'b1;
              key_code_n  = cand;
              key_held_n  = 1'b1;
            end else begin
              fcnt_n = fcnt + CW'(1);
            end
          end else begin
            state_n = IDLE;
            fcnt_n  = '0;
          end
        end
        HELD: begin
          if (f_none) begin
            if (rcnt == CW'(DEBOUNCE_FRAMES - 1)) begin
              key_held_n = 1'b0;
              rcnt_n     = '0;
              state_n    = IDLE;
            end else begin
              rcnt_n = rcnt + CW'(1);
            end
          end else begin
            rcnt_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    data_n = clr ? 32'h0 : data;
    if (accept) begin
      data_n = {data_n[28:1], cand};
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= 4'd0;
      fcnt      <= '0;
      rcnt      <= '0;
      data      <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      fcnt      <= fcnt_n;
      rcnt      <= rcnt_n;
      data      <= data_n;
      key_code  <= key_code_n;
      key_valid <= key_valid_n;
      key_held  <= key_held_n;
    end
  end

endmodule

// File: tb/tb_hex_keypad_entry.sv
// tb_hex_keypad_entry: directed keypad scenarios with a
// matrix model driving row_n from col_n.
module tb_hex_keypad_entry;

  logic        clk;
  logic        rst;
  logic [3:0]  row_n;
  logic        clr;
  logic [3:0]  col_n;
  logic [32:1] data;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys;
  int          n_chk;
  int          n_pass;
  int          kv_cnt;
  int          b2b;
  logic        kv_q;

  hex_keypad_entry #(
    .SCAN_DIV(4),
    .DEBOUNCE_FRAMES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .row_n(row_n),
    .clr(clr),
    .col_n(col_n),
    .data(data),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: key index = {row, col}.
  always_comb begin
    for (int r = 0; r < 4; r++)
      row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
  end

  always @(posedge clk) begin
    kv_q <= key_valid;
    if (key_valid) kv_cnt <= kv_cnt + 1;
    if (key_valid && kv_q) b2b <= b2b + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic press(input int code, input int frames);
    keys = 16'(1) << code;
    repeat (frames * 16) @(negedge clk);
  endtask

  task automatic release_all();
    keys = 16'h0;
    repeat (6 * 16) @(negedge clk);
  endtask

  initial begin
    int k0;
    logic [3:0] pc;
    logic found;
    n_chk  = 0;
    n_pass = 0;
    kv_cnt = 0;
    b2b    = 0;
    kv_q   = 1'b0;
    keys   = 16'h0;
    clr    = 1'b0;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_col_n", 32'(col_n), 32'hE);
    chk("rst_data", data, 32'h0);
    chk("rst_code", 32'(key_code), 32'h0);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_held", 32'(key_held), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    k0 = kv_cnt;
    press(5, 10);
    chk("k5_pulses", 32'(kv_cnt - k0), 32'd1);
    chk("k5_code", 32'(key_code), 32'h5);
    chk("k5_data", data, 32'h5);
    chk("k5_held", 32'(key_held), 32'h1);
    chk("col_onehot", 32'($onehot(~col_n)), 32'h1);
    release_all();
    chk("k5_rel", 32'(key_held), 32'h0);

    k0 = kv_cnt;
    press(10, 10);
    chk("kA_pulses", 32'(kv_cnt - k0), 32'd1);
    chk("kA_code", 32'(key_code), 32'hA);
    chk("kA_data", data, 32'h5A);
    chk("kA_held", 32'(key_held), 32'h1);
    release_all();
    chk("kA_rel", 32'(key_held), 32'h0);

    k0 = kv_cnt;
    press(3, 1);
    release_all();
    chk("bounce_pulses", 32'(kv_cnt - k0), 32'd0);
    chk("bounce_data", data, 32'h5A);
    chk("bounce_held", 32'(key_held), 32'h0);

    k0 = kv_cnt;
    keys = 16'h0006;
    repeat (10 * 16) @(negedge clk);
    chk("multi_pulses", 32'(kv_cnt - k0), 32'd0);
    chk("multi_data", data, 32'h5A);
    chk("multi_held", 32'(key_held), 32'h0);
    release_all();

    k0 = kv_cnt;
    for (int d = 1; d <= 9; d++) begin
      press(d, 10);
      release_all();
    end
    chk("nine_pulses", 32'(kv_cnt - k0), 32'd9);
    chk("nine_data", data, 32'h2345_6789);
    chk("nine_code", 32'(key_code), 32'h9);

    pc = col_n;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (pc == 4'b0111 && col_n == 4'b1110) found = 1'b1;
      pc = col_n;
    end
    chk("align", 32'(found), 32'h1);
    k0 = kv_cnt;
    keys = 16'h0080;
    repeat (39) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_col_n", 32'(col_n), 32'hE);
    chk("mid_rst_data", data, 32'h0);
    chk("mid_rst_valid", 32'(key_valid), 32'h0);
    chk("mid_rst_held", 32'(key_held), 32'h0);
    keys = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_rst_pulses", 32'(kv_cnt - k0), 32'd0);

    press(5, 10);
    release_all();
    chk("pre_clr_data", data, 32'h5);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_data", data, 32'h0);
    chk("post_clr_valid", 32'(key_valid), 32'h0);
    chk("valid_b2b", 32'(b2b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
